// File: rtl/score_pkg.sv
// Shared types and constants for the score/serve controller.
// Holds the game state encoding, counter widths, digit glyph bitmaps and
// the fixed on-screen positions of both score digits.
package score_pkg;

  localparam int MAX_SCORE    = 5;
  localparam int SERVE_FRAMES = 60;

  // Counter wide enough for the largest legal winning score (9).
  localparam int M_SCORE_W = 4;
  localparam int SERVE_W   = 8;

  // Digit bitmap geometry: SCORE_H rows of SCORE_W pixels, row 0 in the MSBs.
  localparam int SCORE_H = 5;
  localparam int SCORE_W = 3;

  localparam logic [9:0] P_SCORE_X = 10'd200;
  localparam logic [9:0] P_SCORE_Y = 10'd16;
  localparam logic [9:0] E_SCORE_X = 10'd424;
  localparam logic [9:0] E_SCORE_Y = 10'd16;

  typedef enum logic [1:0] {
    ST_WAIT_START = 2'd0,
    ST_SERVE      = 2'd1,
    ST_PLAY       = 2'd2
  } game_state_e;

  typedef logic [SCORE_H*SCORE_W-1:0] glyph_t;

  typedef struct packed {
    glyph_t     score_val;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
  } score_t;

  localparam glyph_t score0 = 15'b111_101_101_101_111;
  localparam glyph_t score1 = 15'b010_110_010_010_111;
  localparam glyph_t score2 = 15'b111_001_111_100_111;
  localparam glyph_t score3 = 15'b111_001_111_001_111;
  localparam glyph_t score4 = 15'b101_101_111_001_001;
  localparam glyph_t score5 = 15'b111_100_111_001_111;
  localparam glyph_t score6 = 15'b111_100_111_101_111;
  localparam glyph_t score7 = 15'b111_001_001_001_001;
  localparam glyph_t score8 = 15'b111_101_111_101_111;
  localparam glyph_t score9 = 15'b111_101_111_001_111;

endpackage

// File: rtl/score_glyph_rom.sv
// Combinational digit-to-bitmap lookup for the score renderer.
// Ports: digit (counter value in), bitmap (SCORE_H x SCORE_W glyph out).
// Values above 9 fall back to the zero glyph.
module score_glyph_rom
  import score_pkg::*;
(
  input  logic [M_SCORE_W-1:0] digit,
  output glyph_t               bitmap
);

  always_comb begin
    bitmap = score0;
    case (digit)
      M_SCORE_W'(0): bitmap = score0;
      M_SCORE_W'(1): bitmap = score1;
      M_SCORE_W'(2): bitmap = score2;
      M_SCORE_W'(3): bitmap = score3;
      M_SCORE_W'(4): bitmap = score4;
      M_SCORE_W'(5): bitmap = score5;
      M_SCORE_W'(6): bitmap = score6;
      M_SCORE_W'(7): bitmap = score7;
      M_SCORE_W'(8): bitmap = score8;
      M_SCORE_W'(9): bitmap = score9;
      default:       bitmap = score0;
    endcase
  end

endmodule

// File: rtl/score_ctrl.sv
// Match controller: start/serve/play sequencing, goal scoring, win detection.
// Ports: clk_i/rst_ni, frame_end_i, start_i, p_goal_i/e_goal_i in;
//   state_o, ball_en_o, game_over_o, winner_o, p_score_o/e_score_o glyphs out.
module score_ctrl
  import score_pkg::*;
#(
  parameter int MAX_SCORE    = score_pkg::MAX_SCORE,
  parameter int SERVE_FRAMES = score_pkg::SERVE_FRAMES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        frame_end_i,
  input  logic        start_i,
  input  logic        p_goal_i,
  input  logic        e_goal_i,
  output logic [1:0]  state_o,
  output logic        ball_en_o,
  output logic        game_over_o,
  output logic        winner_o,
  output score_t      p_score_o,
  output score_t      e_score_o
);

  localparam logic [M_SCORE_W-1:0] MAX_CNT    = M_SCORE_W'(MAX_SCORE);
  localparam logic [SERVE_W-1:0]   SERVE_LOAD = SERVE_W'(SERVE_FRAMES);

  game_state_e          state_q, state_d;
  logic [M_SCORE_W-1:0] p_cnt_q, p_cnt_d;
  logic [M_SCORE_W-1:0] e_cnt_q, e_cnt_d;
  logic [SERVE_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic                 game_over_q, game_over_d;
  logic                 winner_q, winner_d;

  // Holds "start_i was low last cycle". Clearing it in reset means a button
  // held through reset release cannot masquerade as a fresh press.
  logic                 start_low_q;
  logic                 start_rise;

  logic [M_SCORE_W-1:0] p_inc, e_inc;
  glyph_t               p_glyph, e_glyph;

  assign start_rise = start_i & start_low_q;
  assign p_inc      = p_cnt_q + M_SCORE_W'(1);
  assign e_inc      = e_cnt_q + M_SCORE_W'(1);

  always_comb begin
    state_d     = state_q;
    p_cnt_d     = p_cnt_q;
    e_cnt_d     = e_cnt_q;
    serve_cnt_d = serve_cnt_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    case (state_q)
      ST_WAIT_START: begin
        if (start_rise) begin
          p_cnt_d     = '0;
          e_cnt_d     = '0;
          game_over_d = 1'b0;
          serve_cnt_d = SERVE_LOAD;
          state_d     = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (frame_end_i) begin
          // A zero count can only appear after a reset glitch; leave serve
          // rather than wrapping the counter.
          if (serve_cnt_q <= SERVE_W'(1)) begin
            serve_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q - SERVE_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (p_goal_i && e_goal_i) begin
          // Simultaneous goals cancel: just re-serve.
          serve_cnt_d = SERVE_LOAD;
          state_d     = ST_SERVE;
        end else if (p_goal_i) begin
          if (p_cnt_q < MAX_CNT) p_cnt_d = p_inc;
          if (p_inc >= MAX_CNT) begin
            game_over_d = 1'b1;
            winner_d    = 1'b1;
            state_d     = ST_WAIT_START;
          end else begin
            serve_cnt_d = SERVE_LOAD;
            state_d     = ST_SERVE;
          end
        end else if (e_goal_i) begin
          if (e_cnt_q < MAX_CNT) e_cnt_d = e_inc;
          if (e_inc >= MAX_CNT) begin
            game_over_d = 1'b1;
            winner_d    = 1'b0;
            state_d     = ST_WAIT_START;
          end else begin
            serve_cnt_d = SERVE_LOAD;
            state_d     = ST_SERVE;
          end
        end
      end

      default: state_d = ST_WAIT_START;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_WAIT_START;
      p_cnt_q     <= '0;
      e_cnt_q     <= '0;
      serve_cnt_q <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      start_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_cnt_q     <= p_cnt_d;
      e_cnt_q     <= e_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      start_low_q <= ~start_i;
    end
  end

  score_glyph_rom u_p_glyph (
    .digit  (p_cnt_q),
    .bitmap (p_glyph)
  );

  score_glyph_rom u_e_glyph (
    .digit  (e_cnt_q),
    .bitmap (e_glyph)
  );

  // Glyphs trail the counters by one cycle so the renderer sees a clean
  // registered bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_score_o <= '{score_val: score0, x_pos: P_SCORE_X, y_pos: P_SCORE_Y};
      e_score_o <= '{score_val: score0, x_pos: E_SCORE_X, y_pos: E_SCORE_Y};
    end else begin
      p_score_o <= '{score_val: p_glyph, x_pos: P_SCORE_X, y_pos: P_SCORE_Y};
      e_score_o <= '{score_val: e_glyph, x_pos: E_SCORE_X, y_pos: E_SCORE_Y};
    end
  end

  assign state_o     = state_q;
  assign ball_en_o   = (state_q == ST_PLAY);
  assign game_over_o = game_over_q;
  assign winner_o    = winner_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with a 3-frame serve and 5-point match.
// Latency: glyphs one cycle after counter update; ball enable with state.
// Backpressure: none, all inputs are pulses/levels.
module tb_score_ctrl;
  import score_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       frame_end_i, start_i, p_goal_i, e_goal_i;
  logic [1:0] state_o;
  logic       ball_en_o, game_over_o, winner_o;
  score_t     p_score_o, e_score_o;

  int n_chk  = 0;
  int n_pass = 0;

  // Hand-drawn expected digit bitmaps, 5 rows x 3 pixels, top row first.
  logic [14:0] g [0:5];

  localparam logic [1:0] WAIT  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;

  always #5 clk_i = ~clk_i;

  score_ctrl #(.MAX_SCORE(5), .SERVE_FRAMES(3)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .frame_end_i (frame_end_i),
    .start_i     (start_i),
    .p_goal_i    (p_goal_i),
    .e_goal_i    (e_goal_i),
    .state_o     (state_o),
    .ball_en_o   (ball_en_o),
    .game_over_o (game_over_o),
    .winner_o    (winner_o),
    .p_score_o   (p_score_o),
    .e_score_o   (e_score_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Three frame pulses with a gap cycle each; ends in PLAY.
  task automatic serve();
    for (int i = 0; i < 3; i++) begin
      frame_end_i = 1'b1; step(); frame_end_i = 1'b0; step();
    end
  endtask

  task automatic goal(input logic p, input logic e);
    p_goal_i = p; e_goal_i = e; step(); p_goal_i = 1'b0; e_goal_i = 1'b0;
  endtask

  task automatic chk_glyphs(input string tag, input int p, input int e);
    chk({tag, "_p"}, 32'(p_score_o.score_val), 32'(g[p]));
    chk({tag, "_e"}, 32'(e_score_o.score_val), 32'(g[e]));
  endtask

  initial begin
    g[0] = 15'b111101101101111;
    g[1] = 15'b010110010010111;
    g[2] = 15'b111001111100111;
    g[3] = 15'b111001111001111;
    g[4] = 15'b101101111001001;
    g[5] = 15'b111100111001111;

    rst_ni = 1'b0; frame_end_i = 1'b0; start_i = 1'b0; p_goal_i = 1'b0; e_goal_i = 1'b0;
    step(); step();
    chk("rst_state", 32'(state_o), 32'(WAIT));
    chk("rst_ball", 32'(ball_en_o), 0);
    chk("rst_over", 32'(game_over_o), 0);
    chk("rst_winner", 32'(winner_o), 0);
    chk_glyphs("rst", 0, 0);
    chk("rst_px", 32'(p_score_o.x_pos), 200);
    chk("rst_ey", 32'(e_score_o.y_pos), 16);

    rst_ni = 1'b1; step();
    chk("idle_state", 32'(state_o), 32'(WAIT));
    start_i = 1'b1; step();
    chk("start_serve", 32'(state_o), 32'(SERVE));
    start_i = 1'b0;

    // Goal during serve must be ignored.
    goal(1'b1, 1'b0);
    chk("serve_goal_state", 32'(state_o), 32'(SERVE));
    for (int i = 0; i < 2; i++) begin
      frame_end_i = 1'b1; step(); frame_end_i = 1'b0; step();
    end
    chk("serve_2frames", 32'(state_o), 32'(SERVE));
    chk("serve_2frames_ball", 32'(ball_en_o), 0);
    frame_end_i = 1'b1; step(); frame_end_i = 1'b0;
    chk("serve_3rd_ball", 32'(ball_en_o), 1);
    chk("serve_3rd_state", 32'(state_o), 32'(PLAY));
    chk_glyphs("serve_goal_ignored", 0, 0);

    // First player goal: glyph trails the counter by one cycle.
    goal(1'b1, 1'b0);
    chk("pgoal_state", 32'(state_o), 32'(SERVE));
    chk("pgoal_ball", 32'(ball_en_o), 0);
    chk("pgoal_glyph_lag", 32'(p_score_o.score_val), 32'(g[0]));
    step();
    chk_glyphs("pgoal_1", 1, 0);

    // Build to 2:3.
    serve(); goal(1'b0, 1'b1);
    serve(); goal(1'b0, 1'b1);
    serve(); goal(1'b1, 1'b0);
    serve(); goal(1'b0, 1'b1);
    serve();
    chk("play_23", 32'(state_o), 32'(PLAY));
    chk_glyphs("score_23", 2, 3);

    goal(1'b1, 1'b1);
    chk("both_state", 32'(state_o), 32'(SERVE));
    step();
    chk_glyphs("both_23", 2, 3);

    // Goal with coincident frame_end: frame ignored, full serve reloaded.
    serve();
    p_goal_i = 1'b1; frame_end_i = 1'b1; step(); p_goal_i = 1'b0; frame_end_i = 1'b0;
    chk("goal_frame_state", 32'(state_o), 32'(SERVE));
    for (int i = 0; i < 2; i++) begin
      frame_end_i = 1'b1; step(); frame_end_i = 1'b0; step();
    end
    chk("goal_frame_reload", 32'(state_o), 32'(SERVE));
    chk_glyphs("score_33", 3, 3);
    frame_end_i = 1'b1; step(); frame_end_i = 1'b0;
    chk("goal_frame_play", 32'(state_o), 32'(PLAY));

    // Player reaches 5.
    goal(1'b1, 1'b0); serve(); goal(1'b1, 1'b0);
    chk("win_state", 32'(state_o), 32'(WAIT));
    chk("win_over", 32'(game_over_o), 1);
    chk("win_winner", 32'(winner_o), 1);
    chk("win_ball", 32'(ball_en_o), 0);
    step();
    chk_glyphs("win_glyph", 5, 3);

    // Goals and frames while waiting change nothing.
    goal(1'b1, 1'b0); goal(1'b0, 1'b1);
    frame_end_i = 1'b1; step(); frame_end_i = 1'b0; step();
    chk("wait_state", 32'(state_o), 32'(WAIT));
    chk("wait_over", 32'(game_over_o), 1);
    chk_glyphs("wait_glyph", 5, 3);

    // Restart clears scores and game_over.
    start_i = 1'b1; step();
    chk("restart_state", 32'(state_o), 32'(SERVE));
    chk("restart_over", 32'(game_over_o), 0);
    step();
    chk_glyphs("restart_glyph", 0, 0);
    start_i = 1'b0;

    // Enemy wins 0:5.
    for (int i = 0; i < 5; i++) begin
      serve(); goal(1'b0, 1'b1);
    end
    chk("ewin_state", 32'(state_o), 32'(WAIT));
    chk("ewin_over", 32'(game_over_o), 1);
    chk("ewin_winner", 32'(winner_o), 0);
    step();
    chk_glyphs("ewin_glyph", 0, 5);

    // New match to 4:1, then reset mid-play with start held.
    start_i = 1'b1; step(); start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve(); goal(1'b1, 1'b0);
    end
    serve(); goal(1'b0, 1'b1);
    serve();
    chk_glyphs("score_41", 4, 1);
    start_i = 1'b1; step();
    chk("start_in_play", 32'(state_o), 32'(PLAY));
    rst_ni = 1'b0; #1;
    chk("async_rst_state", 32'(state_o), 32'(WAIT));
    chk("async_rst_ball", 32'(ball_en_o), 0);
    chk_glyphs("async_rst", 0, 0);
    step();
    rst_ni = 1'b1;
    step(); step(); step();
    chk("held_start_ignored", 32'(state_o), 32'(WAIT));
    start_i = 1'b0; step();
    chk("start_low", 32'(state_o), 32'(WAIT));
    start_i = 1'b1; step();
    chk("start_rearmed", 32'(state_o), 32'(SERVE));
    start_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
